sram_req_arbiter: RTL and testbench

- Shares one sram-like memory port between the instruction-fetch requester (IF stage) and the data requester (EXE stage issue, MEM stage return).
- Grants address phases, and records the owner of each accepted request in an in-order owner FIFO.
- Routes each downstream data_ok/rdata back to the owning requester.
- Data has fixed priority over instruction. A starvation counter guarantees that instruction fetch eventually wins.

---
 rtl/sram_req_arbiter.sv | 130 +++++++++++++
 tb/tb_sram_req_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_req_arbiter.sv
// Two-requester arbiter for a shared sram-like port: data has fixed priority,
// a starvation counter forces instruction fetch through, and an in-order owner FIFO routes returns.
module sram_req_arbiter #(
  parameter int OST_DEPTH  = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       inst_req,
  input  logic                       inst_wr,
  input  logic [1:0]                 inst_size,
  input  logic [3:0]                 inst_wstrb,
  input  logic [31:0]                inst_addr,
  input  logic [31:0]                inst_wdata,
  output logic                       inst_addr_ok,
  output logic                       inst_data_ok,
  output logic [31:0]                inst_rdata,
  input  logic                       data_req,
  input  logic                       data_wr,
  input  logic [1:0]                 data_size,
  input  logic [3:0]                 data_wstrb,
  input  logic [31:0]                data_addr,
  input  logic [31:0]                data_wdata,
  output logic                       data_addr_ok,
  output logic                       data_data_ok,
  output logic [31:0]                data_rdata,
  output logic                       mem_req,
  output logic                       mem_wr,
  output logic [1:0]                 mem_size,
  output logic [3:0]                 mem_wstrb,
  output logic [31:0]                mem_addr,
  output logic [31:0]                mem_wdata,
  input  logic                       mem_addr_ok,
  input  logic                       mem_data_ok,
  input  logic [31:0]                mem_rdata,
  output logic [$clog2(OST_DEPTH):0] ost_cnt,
  output logic                       stray_data_ok
);

  localparam int PW = $clog2(OST_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [OST_DEPTH-1:0] r_owner;
  logic [PW-1:0]        r_head;
  logic [PW-1:0]        r_tail;
  logic [CW-1:0]        r_cnt;
  logic [SW-1:0]        r_starve;
  logic                 r_stray;

  logic w_full;
  logic w_empty;
  logic w_can_issue;
  logic w_force_inst;
  logic w_gnt_data;
  logic w_gnt_inst;
  logic w_push;
  logic w_pop;
  logic w_head_data;

  // Grant, shared-port mux and return routing; everything is gated off while reset is high.
  always_comb begin
    w_full       = (r_cnt == CW'(OST_DEPTH));
    w_empty      = (r_cnt == {CW{1'b0}});
    w_can_issue  = !w_full && !reset;
    w_force_inst = inst_req && (r_starve >= SW'(STARVE_MAX));
    w_gnt_data   = data_req && !w_force_inst;
    w_gnt_inst   = inst_req && !w_gnt_data;
    mem_req      = w_can_issue && (inst_req || data_req);
    if (w_gnt_inst) begin
      mem_wr    = inst_wr;
      mem_size  = inst_size;
      mem_wstrb = inst_wstrb;
      mem_addr  = inst_addr;
      mem_wdata = inst_wdata;
    end else begin
      mem_wr    = data_wr;
      mem_size  = data_size;
      mem_wstrb = data_wstrb;
      mem_addr  = data_addr;
      mem_wdata = data_wdata;
    end
    inst_addr_ok  = mem_req && mem_addr_ok && w_gnt_inst;
    data_addr_ok  = mem_req && mem_addr_ok && w_gnt_data;
    w_push        = mem_req && mem_addr_ok;
    w_pop         = mem_data_ok && !w_empty && !reset;
    w_head_data   = r_owner[r_head];
    inst_data_ok  = w_pop && !w_head_data;
    data_data_ok  = w_pop && w_head_data;
    inst_rdata    = mem_rdata;
    data_rdata    = mem_rdata;
    ost_cnt       = r_cnt;
    stray_data_ok = r_stray;
  end

  // Owner FIFO, outstanding count, starvation counter and sticky stray-return flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner  <= {OST_DEPTH{1'b0}};
      r_head   <= {PW{1'b0}};
      r_tail   <= {PW{1'b0}};
      r_cnt    <= {CW{1'b0}};
      r_starve <= {SW{1'b0}};
      r_stray  <= 1'b0;
    end else begin
      if (w_push) begin
        r_owner[r_tail] <= w_gnt_data;
        r_tail          <= r_tail + PW'(1);
      end
      if (w_pop) begin
        r_head <= r_head + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
      // The counter only measures an unbroken run of denied inst cycles.
      if (!inst_req || inst_addr_ok) begin
        r_starve <= {SW{1'b0}};
      end else if (r_starve < SW'(STARVE_MAX)) begin
        r_starve <= r_starve + SW'(1);
      end
      if (mem_data_ok && w_empty) begin
        r_stray <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Bench for sram_req_arbiter: directed scenarios plus a random run, all checked
// against a queue-based model of ownership, priority and starvation.
module tb_sram_req_arbiter;

  localparam int OST_DEPTH  = 4;
  localparam int STARVE_MAX = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [3:0]  inst_wstrb, data_wstrb;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  ost_cnt;
  logic        stray_data_ok;

  sram_req_arbiter #(.OST_DEPTH(OST_DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .ost_cnt(ost_cnt), .stray_data_ok(stray_data_ok)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference state: owners of accepted requests in order, starvation run length, stray flag.
  bit model_q[$];
  int m_starve = 0;
  bit m_stray  = 1'b0;

  // Observed values of the most recent cycle, for directed checks.
  logic o_mreq, o_iaok, o_daok, o_idok, o_ddok, o_stray;
  logic [31:0] o_cnt, o_rdata;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic rand_inst();
    inst_wr    = 1'($urandom_range(0, 1));
    inst_size  = 2'($urandom_range(0, 2));
    inst_wstrb = 4'($urandom);
    inst_addr  = $urandom;
    inst_wdata = $urandom;
  endtask

  task automatic rand_data();
    data_wr    = 1'($urandom_range(0, 1));
    data_size  = 2'($urandom_range(0, 2));
    data_wstrb = 4'($urandom);
    data_addr  = $urandom;
    data_wdata = $urandom;
  endtask

  // One clock cycle: drive at the falling edge, check against the model, then advance the model.
  task automatic step(input bit rst, input bit iq, input bit dq, input bit mao, input bit mdok,
                      input logic [31:0] rd);
    bit full, any, iwin, issue, hs, pop, head;
    @(negedge clk);
    reset = rst; inst_req = iq; data_req = dq;
    mem_addr_ok = mao; mem_data_ok = mdok; mem_rdata = rd;
    #1;
    full  = (model_q.size() == OST_DEPTH);
    any   = iq || dq;
    iwin  = iq && (!dq || (m_starve >= STARVE_MAX));
    issue = !rst && !full && any;
    hs    = issue && mao;
    pop   = !rst && mdok && (model_q.size() > 0);
    head  = pop ? model_q[0] : 1'b0;
    check_val("mem_req", {31'd0, mem_req}, {31'd0, issue});
    check_val("inst_addr_ok", {31'd0, inst_addr_ok}, {31'd0, hs && iwin});
    check_val("data_addr_ok", {31'd0, data_addr_ok}, {31'd0, hs && !iwin});
    check_val("inst_data_ok", {31'd0, inst_data_ok}, {31'd0, pop && !head});
    check_val("data_data_ok", {31'd0, data_data_ok}, {31'd0, pop && head});
    check_val("inst_rdata", inst_rdata, rd);
    check_val("data_rdata", data_rdata, rd);
    check_val("ost_cnt", {29'd0, ost_cnt}, 32'(model_q.size()));
    check_val("stray_data_ok", {31'd0, stray_data_ok}, {31'd0, m_stray});
    if (issue) begin
      check_val("mem_addr", mem_addr, iwin ? inst_addr : data_addr);
      check_val("mem_wdata", mem_wdata, iwin ? inst_wdata : data_wdata);
      check_val("mem_ctrl", {25'd0, mem_wr, mem_size, mem_wstrb},
                iwin ? {25'd0, inst_wr, inst_size, inst_wstrb} : {25'd0, data_wr, data_size, data_wstrb});
    end
    o_mreq = mem_req; o_iaok = inst_addr_ok; o_daok = data_addr_ok;
    o_idok = inst_data_ok; o_ddok = data_data_ok; o_stray = stray_data_ok;
    o_cnt = {29'd0, ost_cnt}; o_rdata = data_rdata;
    if (rst) begin
      model_q.delete();
      m_starve = 0;
      m_stray  = 1'b0;
    end else begin
      if (mdok && (model_q.size() == 0)) m_stray = 1'b1;
      if (pop) void'(model_q.pop_front());
      if (hs) model_q.push_back(!iwin);
      if (iq && !(hs && iwin)) m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX;
      else m_starve = 0;
    end
  endtask

  task automatic idle(input bit mdok, input logic [31:0] rd);
    step(1'b0, 1'b0, 1'b0, 1'b0, mdok, rd);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  initial begin
    bit i_pend, d_pend, iq, dq, mao, mdok;
    reset = 1'b1; inst_req = 1'b0; data_req = 1'b0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'd0;
    rand_inst(); rand_data();
    do_reset();
    do_reset();
    check_val("reset_cnt", o_cnt, 32'd0);

    // Single inst read with a two-cycle return.
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
    check_val("t1_iaok", {31'd0, o_iaok}, 32'd1);
    idle(1'b0, 32'd0);
    check_val("t1_cnt1", o_cnt, 32'd1);
    idle(1'b1, 32'h1234_5678);
    check_val("t1_idok", {31'd0, o_idok}, 32'd1);
    check_val("t1_ddok", {31'd0, o_ddok}, 32'd0);
    idle(1'b0, 32'd0);
    check_val("t1_cnt0", o_cnt, 32'd0);

    // Both requesting every cycle: data wins until the starvation threshold.
    do_reset();
    for (int k = 0; k < 9; k++) begin
      step(1'b0, 1'b1, 1'b1, 1'b1, model_q.size() > 0, $urandom);
      if (k < 8) check_val("starve_data_gnt", {31'd0, o_daok}, 32'd1);
      else check_val("starve_inst_gnt", {31'd0, o_iaok}, 32'd1);
      if (o_daok) rand_data();
    end
    idle(1'b1, 32'h0000_0009);
    check_val("starve_inst_ret", {31'd0, o_idok}, 32'd1);

    // Fill to OST_DEPTH, then one return frees a slot a cycle later.
    do_reset();
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
    check_val("full_block", {31'd0, o_mreq}, 32'd0);
    check_val("full_cnt", o_cnt, 32'd4);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h5555_0000);
    check_val("full_pop_block", {31'd0, o_mreq}, 32'd0);
    check_val("full_pop_ddok", {31'd0, o_ddok}, 32'd1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
    check_val("full_resume", {31'd0, o_daok}, 32'd1);
    for (int k = 0; k < 4; k++) idle(1'b1, $urandom);

    // Interleaved D, I, D with in-order returns.
    do_reset();
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
    idle(1'b1, 32'h0000_000A);
    check_val("ilv_d1", {31'd0, o_ddok}, 32'd1);
    check_val("ilv_d1_data", o_rdata, 32'h0000_000A);
    idle(1'b1, 32'h0000_000B);
    check_val("ilv_i", {31'd0, o_idok}, 32'd1);
    idle(1'b1, 32'h0000_000C);
    check_val("ilv_d2", {31'd0, o_ddok}, 32'd1);

    // Return with nothing outstanding is sticky until reset.
    do_reset();
    idle(1'b1, 32'hDEAD_BEEF);
    check_val("stray_no_idok", {31'd0, o_idok}, 32'd0);
    check_val("stray_no_ddok", {31'd0, o_ddok}, 32'd0);
    idle(1'b0, 32'd0);
    check_val("stray_set", {31'd0, o_stray}, 32'd1);
    idle(1'b0, 32'd0);
    check_val("stray_hold", {31'd0, o_stray}, 32'd1);
    do_reset();
    idle(1'b0, 32'd0);
    check_val("stray_clr", {31'd0, o_stray}, 32'd0);

    // Reset discards outstanding ownership.
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
    do_reset();
    idle(1'b0, 32'd0);
    check_val("rst_ost_cnt", o_cnt, 32'd0);
    idle(1'b1, 32'h0000_0001);
    idle(1'b0, 32'd0);
    check_val("rst_stray", {31'd0, o_stray}, 32'd1);

    // Random traffic; requesters hold their fields until accepted.
    do_reset();
    i_pend = 1'b0; d_pend = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (!i_pend) rand_inst();
      if (!d_pend) rand_data();
      iq   = i_pend || ($urandom_range(0, 2) != 0);
      dq   = d_pend || ($urandom_range(0, 2) != 0);
      mao  = ($urandom_range(0, 3) != 0);
      mdok = (model_q.size() > 0) && ($urandom_range(0, 1) != 0);
      step(1'b0, iq, dq, mao, mdok, $urandom);
      i_pend = iq && !o_iaok;
      d_pend = dq && !o_daok;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
